// File: rtl/shift_reg_param.sv
// Parametrised universal shift register: hold, parallel load, shift left/right with a saturating shift counter.
// Define SHIFT_REG_ROTATE_EN to make both shift modes rotate instead of taking SI.
module shift_reg_param #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '1,
    parameter int unsigned       CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO_MSB,
    output logic             SO_LSB,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mode_t            mode;
    logic             in_left;
    logic             in_right;
    logic [WIDTH-1:0] q_shl;
    logic [WIDTH-1:0] q_shr;

    assign mode = mode_t'(MODE);

`ifdef SHIFT_REG_ROTATE_EN
    logic unused_si;
    assign unused_si = SI;
`endif

    always_comb begin
`ifdef SHIFT_REG_ROTATE_EN
        in_left  = Q[WIDTH-1];
        in_right = Q[0];
`else
        in_left  = SI;
        in_right = SI;
`endif
        q_shl = {Q[WIDTH-2:0], in_left};
        q_shr = {in_right, Q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q    <= RESET_VALUE;
            cnt  <= '0;
            done <= 1'b0;
        end else if (E) begin
            case (mode)
                MODE_HOLD: begin
                end
                MODE_LOAD: begin
                    Q    <= D;
                    cnt  <= '0;
                    done <= 1'b0;
                end
                MODE_SHL, MODE_SHR: begin
                    Q <= (mode == MODE_SHL) ? q_shl : q_shr;
                    // Counter saturates at WIDTH; done rises on the edge that reaches it and then sticks.
                    if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                    if (cnt >= CNT_LAST) done <= 1'b1;
                end
            endcase
        end
    end

    assign SO_MSB = Q[WIDTH-1];
    assign SO_LSB = Q[0];

endmodule
